// File: rtl/sdram_mem_port.sv
// CPU-side port onto the SDRAM block interface: single-word loads/stores become
// 128-bit block reads and write-through read-modify-writes via a one-line buffer.
module sdram_mem_port #(
  parameter int BLOCK_BITS = 128,
  parameter int WORD_BITS  = 32,
  parameter int ADDR_BITS  = 26
) (
  input  logic                                        iclk,
  input  logic                                        ireset_n,
  input  logic                                        icpu_req,
  input  logic                                        icpu_we,
  input  logic [ADDR_BITS-1:0]                        icpu_addr,
  input  logic [WORD_BITS-1:0]                        icpu_wdata,
  input  logic [WORD_BITS/8-1:0]                      icpu_be,
  output logic [WORD_BITS-1:0]                        ocpu_rdata,
  output logic                                        ocpu_ready,
  output logic                                        ocpu_busy,
  output logic                                        oread_req,
  output logic [ADDR_BITS-$clog2(BLOCK_BITS/8)-1:0]   oread_address,
  input  logic [BLOCK_BITS-1:0]                       iread_data,
  input  logic                                        iread_ack,
  output logic                                        owrite_req,
  output logic [ADDR_BITS-$clog2(BLOCK_BITS/8)-1:0]   owrite_address,
  output logic [BLOCK_BITS-1:0]                       owrite_data,
  input  logic                                        iwrite_ack,
  input  logic                                        iin_use
);

  localparam int OFF_BITS = $clog2(BLOCK_BITS/8);
  localparam int WORDS    = BLOCK_BITS/WORD_BITS;
  localparam int SEL_BITS = $clog2(WORDS);
  localparam int TAG_BITS = ADDR_BITS - OFF_BITS;
  localparam int LANES    = WORD_BITS/8;

  typedef enum logic [2:0] {IDLE, RD_REQ, MERGE, WR_REQ, RESP} state_t;

  state_t state, state_next;

  logic                  cap_we;
  logic [TAG_BITS-1:0]   cap_tag;
  logic [SEL_BITS-1:0]   cap_sel;
  logic [WORD_BITS-1:0]  cap_wdata;
  logic [LANES-1:0]      cap_be;

  logic [BLOCK_BITS-1:0] buf_data;
  logic [TAG_BITS-1:0]   buf_tag;
  logic                  buf_valid;

  logic [BLOCK_BITS-1:0] merged;
  logic [WORD_BITS-1:0]  buf_word;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic                  rd_done;
  logic                  wr_done;
  logic                  unused_byte_bits;

  assign req_tag          = icpu_addr[ADDR_BITS-1:OFF_BITS];
  assign hit              = buf_valid && (buf_tag == req_tag);
  assign unused_byte_bits = ^icpu_addr[OFF_BITS-SEL_BITS-1:0];

  // An ack only counts while our own request is outstanding in the matching state.
  assign rd_done = (state == RD_REQ) && oread_req && iread_ack;
  assign wr_done = (state == WR_REQ) && owrite_req && iwrite_ack;

  always_comb begin
    merged   = buf_data;
    buf_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (cap_sel == SEL_BITS'(w)) begin
        buf_word = buf_data[w*WORD_BITS +: WORD_BITS];
        for (int unsigned b = 0; b < LANES; b++) begin
          if (cap_be[b]) merged[w*WORD_BITS + b*8 +: 8] = cap_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (!ireset_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (icpu_req) begin
          if (icpu_we) begin
            if (icpu_be == '0) state_next = RESP;
            else if (hit)      state_next = MERGE;
            else               state_next = RD_REQ;
          end else begin
            state_next = hit ? RESP : RD_REQ;
          end
        end
      end
      RD_REQ:  if (rd_done) state_next = cap_we ? MERGE : RESP;
      MERGE:   state_next = WR_REQ;
      WR_REQ:  if (wr_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ocpu_ready = (state == RESP);
    ocpu_busy  = (state != IDLE);
    ocpu_rdata = '0;
    if ((state == RESP) && !cap_we) ocpu_rdata = buf_word;
  end

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      oread_req      <= 1'b0;
      owrite_req     <= 1'b0;
      oread_address  <= '0;
      owrite_address <= '0;
      owrite_data    <= '0;
      buf_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (icpu_req && (state_next == RD_REQ)) oread_address <= req_tag;
        RD_REQ: begin
          if (rd_done) begin
            oread_req <= 1'b0;
            buf_valid <= 1'b1;
          end else if (!oread_req && !iin_use) begin
            oread_req <= 1'b1;
          end
        end
        MERGE: begin
          owrite_address <= buf_tag;
          owrite_data    <= merged;
        end
        WR_REQ: begin
          if (wr_done)                      owrite_req <= 1'b0;
          else if (!owrite_req && !iin_use) owrite_req <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Buffer contents and captured request need no reset: buf_valid gates their use.
  always_ff @(posedge iclk) begin
    if ((state == IDLE) && icpu_req) begin
      cap_we    <= icpu_we;
      cap_tag   <= req_tag;
      cap_sel   <= icpu_addr[OFF_BITS-1:OFF_BITS-SEL_BITS];
      cap_wdata <= icpu_wdata;
      cap_be    <= icpu_be;
    end
    if (rd_done) begin
      buf_data <= iread_data;
      buf_tag  <= cap_tag;
    end
    if (state == MERGE) buf_data <= merged;
  end

endmodule

// File: tb/tb_sdram_mem_port.sv
// Directed bench for sdram_mem_port; the bench itself plays the SDRAM controller.
module tb_sdram_mem_port;

  logic          iclk = 1'b0;
  logic          ireset_n;
  logic          icpu_req;
  logic          icpu_we;
  logic [25:0]   icpu_addr;
  logic [31:0]   icpu_wdata;
  logic [3:0]    icpu_be;
  logic [31:0]   ocpu_rdata;
  logic          ocpu_ready;
  logic          ocpu_busy;
  logic          oread_req;
  logic [21:0]   oread_address;
  logic [127:0]  iread_data;
  logic          iread_ack;
  logic          owrite_req;
  logic [21:0]   owrite_address;
  logic [127:0]  owrite_data;
  logic          iwrite_ack;
  logic          iin_use;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int both_hi   = 0;
  int rd_mark;
  int wr_mark;

  localparam logic [127:0] BLK1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] BLK2 = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

  sdram_mem_port #(.BLOCK_BITS(128), .WORD_BITS(32), .ADDR_BITS(26)) dut (
    .iclk(iclk), .ireset_n(ireset_n),
    .icpu_req(icpu_req), .icpu_we(icpu_we), .icpu_addr(icpu_addr),
    .icpu_wdata(icpu_wdata), .icpu_be(icpu_be),
    .ocpu_rdata(ocpu_rdata), .ocpu_ready(ocpu_ready), .ocpu_busy(ocpu_busy),
    .oread_req(oread_req), .oread_address(oread_address),
    .iread_data(iread_data), .iread_ack(iread_ack),
    .owrite_req(owrite_req), .owrite_address(owrite_address),
    .owrite_data(owrite_data), .iwrite_ack(iwrite_ack), .iin_use(iin_use)
  );

  always #5 iclk = ~iclk;

  always @(negedge iclk) begin
    if (oread_req)               rd_cycles++;
    if (owrite_req)              wr_cycles++;
    if (oread_req && owrite_req) both_hi++;
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request for one acceptance edge, then scrambles the CPU inputs.
  task automatic request(input logic we, input logic [25:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    icpu_req   = 1'b1;
    icpu_we    = we;
    icpu_addr  = addr;
    icpu_wdata = wdata;
    icpu_be    = be;
    tick();
    icpu_req   = 1'b0;
    icpu_we    = ~we;
    icpu_addr  = 26'h3FF_FFFF;
    icpu_wdata = 32'h0;
    icpu_be    = 4'h0;
  endtask

  initial begin
    ireset_n = 1'b0; icpu_req = 1'b0; icpu_we = 1'b0; icpu_addr = '0;
    icpu_wdata = '0; icpu_be = '0; iread_data = '0; iread_ack = 1'b0;
    iwrite_ack = 1'b0; iin_use = 1'b0;
    tick(); tick();
    check("rst_ready", ocpu_ready, 0);
    check("rst_busy", ocpu_busy, 0);
    check("rst_rd_req", oread_req, 0);
    check("rst_wr_req", owrite_req, 0);
    check("rst_rdata", ocpu_rdata, 0);
    check("rst_wdata", owrite_data, 0);
    ireset_n = 1'b1;

    // Load miss at 0x10
    request(1'b0, 26'h10, 32'h0, 4'h0);
    check("miss_busy", ocpu_busy, 1);
    check("miss_req_wait", oread_req, 0);
    tick();
    check("miss_rd_req", oread_req, 1);
    check("miss_rd_addr", oread_address, 22'h1);
    iread_data = BLK1; iread_ack = 1'b1;
    tick();
    iread_ack = 1'b0; iread_data = '0;
    check("miss_ready", ocpu_ready, 1);
    check("miss_rdata", ocpu_rdata, 32'h1111_1111);
    check("miss_req_drop", oread_req, 0);
    tick();
    check("miss_ready_pulse", ocpu_ready, 0);
    check("miss_idle_busy", ocpu_busy, 0);

    // Load hit at 0x18
    rd_mark = rd_cycles;
    request(1'b0, 26'h18, 32'h0, 4'h0);
    check("hit_ready", ocpu_ready, 1);
    check("hit_rdata", ocpu_rdata, 32'h3333_3333);
    tick();
    check("hit_ready_pulse", ocpu_ready, 0);
    check("hit_no_read", rd_cycles, rd_mark);

    // Store hit, partial bytes
    request(1'b1, 26'h14, 32'hAABB_CCDD, 4'b0101);
    check("sthit_busy", ocpu_busy, 1);
    tick();
    check("sthit_wr_addr", owrite_address, 22'h1);
    check("sthit_wr_data", owrite_data, 128'h4444_4444_3333_3333_22BB_22DD_1111_1111);
    check("sthit_req_wait", owrite_req, 0);
    tick();
    check("sthit_wr_req", owrite_req, 1);
    iwrite_ack = 1'b1;
    tick();
    iwrite_ack = 1'b0;
    check("sthit_ready", ocpu_ready, 1);
    check("sthit_rdata", ocpu_rdata, 0);
    check("sthit_req_drop", owrite_req, 0);
    tick();
    request(1'b0, 26'h14, 32'h0, 4'h0);
    check("sthit_readback", ocpu_rdata, 32'h22BB_22DD);
    tick();

    // Store miss at 0x400
    request(1'b1, 26'h400, 32'hCAFE_F00D, 4'hF);
    tick();
    check("stmiss_rd_req", oread_req, 1);
    check("stmiss_rd_addr", oread_address, 22'h40);
    check("stmiss_no_wr", owrite_req, 0);
    iread_data = BLK2; iread_ack = 1'b1;
    tick();
    iread_ack = 1'b0; iread_data = '0;
    check("stmiss_rd_drop", oread_req, 0);
    check("stmiss_not_ready", ocpu_ready, 0);
    tick();
    check("stmiss_wr_addr", owrite_address, 22'h40);
    check("stmiss_wr_data", owrite_data, 128'h8888_8888_7777_7777_6666_6666_CAFE_F00D);
    tick();
    check("stmiss_wr_req", owrite_req, 1);
    iwrite_ack = 1'b1;
    tick();
    iwrite_ack = 1'b0;
    check("stmiss_ready", ocpu_ready, 1);
    tick();

    // iin_use gating on a load miss back to block 0x1
    iin_use = 1'b1;
    request(1'b0, 26'h10, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_hold", oread_req, 0);
    end
    iin_use = 1'b0;
    tick();
    check("gate_release", oread_req, 1);
    iread_data = BLK1; iread_ack = 1'b1;
    tick();
    iread_ack = 1'b0; iread_data = '0;
    check("gate_req_drop", oread_req, 0);
    check("gate_ready", ocpu_ready, 1);
    check("gate_rdata", ocpu_rdata, 32'h1111_1111);
    tick();

    // Reset during WR_REQ, then a late write ack
    request(1'b1, 26'h10, 32'h1234_5678, 4'hF);
    tick(); tick();
    check("mid_wr_req", owrite_req, 1);
    ireset_n = 1'b0;
    tick();
    ireset_n = 1'b1;
    check("mid_rst_busy", ocpu_busy, 0);
    check("mid_rst_ready", ocpu_ready, 0);
    check("mid_rst_wr_req", owrite_req, 0);
    check("mid_rst_rd_req", oread_req, 0);
    check("mid_rst_wr_addr", owrite_address, 0);
    check("mid_rst_rd_addr", oread_address, 0);
    check("mid_rst_wr_data", owrite_data, 0);
    iwrite_ack = 1'b1;
    tick();
    iwrite_ack = 1'b0;
    check("late_ack_busy", ocpu_busy, 0);
    check("late_ack_ready", ocpu_ready, 0);
    request(1'b0, 26'h10, 32'h0, 4'h0);
    check("post_rst_miss_busy", ocpu_busy, 1);
    tick();
    check("post_rst_rd_req", oread_req, 1);
    check("post_rst_rd_addr", oread_address, 22'h1);
    iread_data = BLK1; iread_ack = 1'b1;
    tick();
    iread_ack = 1'b0; iread_data = '0;
    check("post_rst_rdata", ocpu_rdata, 32'h1111_1111);
    tick();

    // Zero byte-enable store
    rd_mark = rd_cycles;
    wr_mark = wr_cycles;
    request(1'b1, 26'h1C, 32'hFFFF_FFFF, 4'h0);
    check("be0_ready", ocpu_ready, 1);
    check("be0_rdata", ocpu_rdata, 0);
    tick();
    check("be0_idle", ocpu_busy, 0);
    request(1'b0, 26'h1C, 32'h0, 4'h0);
    check("be0_hit_ready", ocpu_ready, 1);
    check("be0_buffer_kept", ocpu_rdata, 32'h4444_4444);
    tick();
    check("be0_no_read", rd_cycles, rd_mark);
    check("be0_no_write", wr_cycles, wr_mark);

    check("req_exclusive", both_hi, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sdram_mem_port.md
Name: sdram_mem_port

Overview:
- Initiator-side client of the SDRAM controller's block request/ack interface; the controller is the responder.
- Converts single-word CPU loads/stores into 128-bit block reads and writes.
- Stores are handled as read-modify-write.
- A one-line block buffer serves repeated accesses and is written through on every store.
- Sits between the core's data/instruction memory bus and the SDRAM controller.

Parameters:
- BLOCK_BITS, 128, SDRAM block width; must equal controller data block width (8 columns x 16-bit DQ).
- WORD_BITS, 32, CPU word width; BLOCK_BITS/WORD_BITS = 4 words per block.
- ADDR_BITS, 26, CPU byte address width; addr[25:4] = block address, addr[3:2] = word select, addr[1:0] ignored.

Ports:
- iclk  in  1  clock.
- ireset_n  in  1  synchronous active-low reset.
- icpu_req  in  1  CPU access request; sampled only in IDLE.
- icpu_we  in  1  1 = store, 0 = load.
- icpu_addr  in  26  byte address.
- icpu_wdata  in  32  store data.
- icpu_be  in  4  store byte enables; bit i covers bits [8i+7:8i].
- ocpu_rdata  out  32  load data; valid while ocpu_ready = 1.
- ocpu_ready  out  1  one-cycle completion pulse.
- ocpu_busy  out  1  high in every state except IDLE.
- oread_req  out  1  block read request to controller.
- oread_address  out  22  block address for read.
- iread_data  in  128  block read data; valid when iread_ack = 1.
- iread_ack  in  1  controller read-done pulse.
- owrite_req  out  1  block write request to controller.
- owrite_address  out  22  block address for write.
- owrite_data  out  128  block write data.
- iwrite_ack  in  1  controller write-done pulse.
- iin_use  in  1  controller busy flag.

Behaviour:
- Reset (ireset_n = 0 at a clock edge), from any state including mid-operation:
  - state goes to IDLE.
  - ocpu_ready, ocpu_busy, oread_req and owrite_req go to 0.
  - ocpu_rdata, oread_address, owrite_address and owrite_data go to 0.
  - The buffer is marked invalid.
  - Ack pulses arriving after reset are ignored.
- Acceptance:
  - In IDLE with icpu_req = 1, the block captures we, addr, wdata and be into registers.
  - The CPU may change its inputs from the next cycle on.
- Hit: buffer valid and buffer tag == addr[25:4].
- States: IDLE, RD_REQ, MERGE, WR_REQ, RESP.
- IDLE transitions:
  - load hit -> RESP.
  - load miss -> RD_REQ.
  - store with be == 0 -> RESP; no SDRAM traffic, buffer unchanged.
  - store hit -> MERGE.
  - store miss -> RD_REQ.
- RD_REQ:
  - oread_req is set when iin_use = 0 and is held until iread_ack.
  - oread_req is cleared on the edge where iread_ack = 1, so it is low when the controller returns to its idle state and is never re-sampled.
  - On iread_ack: buffer <= iread_data, tag <= block address, valid <= 1.
  - Next state: MERGE for a store, RESP for a load.
- MERGE (1 cycle):
  - Byte-lane merge of wdata into buffer word addr[3:2]; word 0 = bits [31:0].
  - owrite_data <= merged block, owrite_address <= tag; buffer updated to the merged block.
  - Next state: WR_REQ.
- WR_REQ:
  - owrite_req follows the same rules as oread_req, against iwrite_ack.
  - On iwrite_ack -> RESP.
- RESP (1 cycle):
  - ocpu_ready = 1.
  - For a load, ocpu_rdata = buffer word addr[3:2]; for a store, ocpu_rdata = 0.
  - Next state: IDLE. A new request may be accepted in the following cycle.
- Latencies, counted from the acceptance edge:
  - load hit: ready 1 cycle later.
  - load miss: ready 1 cycle after iread_ack.
  - store: ready 1 cycle after iwrite_ack.
- Invariants:
  - oread_req and owrite_req are never high together.
  - An ack pulse seen in the wrong state, or with no pending request, is ignored.
- Coherence: the buffer always mirrors SDRAM contents for its tag (write-through). No other SDRAM client is supported.

Test Plan:
- Load miss then hit:
  - Load 0x0000010 -> oread_req with address 0x000001.
  - Controller returns block 0x4444_4444_3333_3333_2222_2222_1111_1111 with ack.
  - -> ready 1 cycle after ack with rdata 0x1111_1111; no SDRAM request issued for the hit load described next.
  - Then load 0x0000018 -> rdata 0x3333_3333, ready 1 cycle after acceptance.
- Store hit with partial bytes:
  - Buffered block as above; store 0x0000014, wdata 0xAABBCCDD, be = 4'b0101.
  - -> owrite_address 0x000001, word1 = 0x22BB22DD, other words unchanged.
  - -> ready 1 cycle after iwrite_ack.
- Store miss:
  - Store 0x0000400 with be = 4'hF.
  - -> read of block 0x000040 completes first, then write of the merged block.
  - -> oread_req and owrite_req are never both high.
- iin_use gating and req drop:
  - Hold iin_use = 1 for 5 cycles at a miss -> oread_req stays 0 until iin_use falls.
  - -> oread_req is 0 the cycle after iread_ack.
- Reset mid-op:
  - ireset_n = 0 during WR_REQ -> all outputs 0, state IDLE.
  - -> a following load to the previous tag misses and issues an SDRAM read.
  - Late iwrite_ack -> ignored.
- Zero byte-enable store:
  - be = 0 -> ready 1 cycle after acceptance.
  - -> no oread_req/owrite_req; buffer contents unchanged.
